// File: rtl/mips_pkg.sv
// Shared widths, control-bit positions and opcodes for the 5-stage MIPS datapath.
package mips_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_BEQ   = 6'h04
  } opcode_t;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load sitting in ID/EX and the instruction in IF/ID.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             hazard,
  output logic             stall
);

  logic load_dest;
  logic src_match;

  // Both source fields are compared regardless of opcode; a spurious stall is harmless.
  assign load_dest = ex_valid & ex_memread & (ex_rt != '0);
  assign src_match = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign hazard    = load_dest & id_valid & src_match;

  // The IF/ID instruction is discarded on a flush, so there is nothing to stall for.
  assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash and
// saturating stall/flush event counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [EX_W-1:0]   ex_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              cnt_clr,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [EX_W-1:0]   ex_out,
  output logic [DATA_W-1:0] pc4_out,
  output logic [DATA_W-1:0] rdata1_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_W-1:0]  rs_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              valid_out,
  output logic              stall,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic hazard;
  logic kill_ctrl;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .ex_valid   (valid_out),
    .ex_memread (m_out[M_MEMREAD]),
    .ex_rt      (rt_out),
    .id_valid   (id_valid),
    .id_rs      (rs_in),
    .id_rt      (rt_in),
    .flush      (flush),
    .hazard     (hazard),
    .stall      (stall)
  );

  assign pc_write_en   = ~stall;
  assign ifid_write_en = ~stall;

  // Flush, bubble and an empty IF/ID all turn the entering slot into a no-op.
  assign kill_ctrl = flush | stall | ~id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_out     <= '0;
      m_out      <= '0;
      ex_out     <= '0;
      valid_out  <= 1'b0;
      pc4_out    <= '0;
      rdata1_out <= '0;
      rdata2_out <= '0;
      imm_out    <= '0;
      rs_out     <= '0;
      rt_out     <= '0;
      rd_out     <= '0;
    end else begin
      if (kill_ctrl) begin
        wb_out <= '0;
        m_out  <= '0;
        ex_out <= '0;
      end else begin
        wb_out <= wb_in;
        m_out  <= m_in;
        ex_out <= ex_in;
      end
      valid_out  <= id_valid & ~flush & ~stall;
      pc4_out    <= pc4_in;
      rdata1_out <= rdata1_in;
      rdata2_out <= rdata2_in;
      imm_out    <= imm_in;
      rs_out     <= rs_in;
      rt_out     <= rt_in;
      rd_out     <= rd_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model pushes expected ID/EX contents
// per edge and each test task pops and compares them after the edge.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        id_valid;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [3:0]  ex_in;
  logic [31:0] pc4_in, rdata1_in, rdata2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        cnt_clr;

  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [3:0]  ex_out;
  logic [31:0] pc4_out, rdata1_out, rdata2_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        valid_out, stall, pc_write_en, ifid_write_en;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_wb_out;
  logic [2:0]  s_m_out;
  logic [3:0]  s_ex_out;
  logic [31:0] s_pc4_out, s_rdata1_out, s_rdata2_out, s_imm_out;
  logic [4:0]  s_rs_out, s_rt_out, s_rd_out;
  logic        s_valid_out, s_stall, s_pc_write_en, s_ifid_write_en;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in), .pc4_in(pc4_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .cnt_clr(cnt_clr),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out), .pc4_out(pc4_out),
    .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out),
    .stall(stall), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in), .pc4_in(pc4_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .cnt_clr(cnt_clr),
    .wb_out(s_wb_out), .m_out(s_m_out), .ex_out(s_ex_out), .pc4_out(s_pc4_out),
    .rdata1_out(s_rdata1_out), .rdata2_out(s_rdata2_out), .imm_out(s_imm_out),
    .rs_out(s_rs_out), .rt_out(s_rt_out), .rd_out(s_rd_out), .valid_out(s_valid_out),
    .stall(s_stall), .pc_write_en(s_pc_write_en), .ifid_write_en(s_ifid_write_en),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc4;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } st_t;

  st_t mdl;
  st_t sb[$];
  int  mstall, mflush, mstall_s, mflush_s;
  int  checks = 0;
  int  errors = 0;

  function automatic st_t get_act();
    get_act = {wb_out, m_out, ex_out, pc4_out, rdata1_out, rdata2_out, imm_out,
               rs_out, rt_out, rd_out, valid_out};
  endfunction

  function automatic logic exp_stall();
    logic hz;
    hz = mdl.valid && mdl.m[1] && (mdl.rt != 5'd0) && id_valid &&
         ((mdl.rt == rs_in) || (mdl.rt == rt_in));
    exp_stall = hz && !flush;
  endfunction

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] imm);
    id_valid  = v;
    wb_in     = wb;
    m_in      = m;
    ex_in     = ex;
    rs_in     = rs;
    rt_in     = rt;
    rd_in     = rd;
    rdata1_in = r1;
    rdata2_in = r1 ^ 32'h5A5A_0000;
    imm_in    = imm;
    pc4_in    = pc4_in + 32'd4;
  endtask

  // Model one rising edge, push the expected ID/EX contents, then advance past the edge.
  task automatic clock_in();
    st_t  nxt;
    logic s;
    s = exp_stall();
    nxt.pc4 = pc4_in;
    nxt.r1  = rdata1_in;
    nxt.r2  = rdata2_in;
    nxt.imm = imm_in;
    nxt.rs  = rs_in;
    nxt.rt  = rt_in;
    nxt.rd  = rd_in;
    if (flush || s || !id_valid) begin
      nxt.wb = 2'b00;
      nxt.m  = 3'b000;
      nxt.ex = 4'b0000;
    end else begin
      nxt.wb = wb_in;
      nxt.m  = m_in;
      nxt.ex = ex_in;
    end
    nxt.valid = id_valid && !flush && !s;
    if (cnt_clr) begin
      mstall = 0; mflush = 0; mstall_s = 0; mflush_s = 0;
    end else begin
      if (s && mstall < 65535) mstall++;
      if (flush && mflush < 65535) mflush++;
      if (s && mstall_s < 3) mstall_s++;
      if (flush && mflush_s < 3) mflush_s++;
    end
    sb.push_back(nxt);
    mdl = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mdl = '0;
    sb.delete();
    mstall = 0; mflush = 0; mstall_s = 0; mflush_s = 0;
  endtask

  task automatic test_reset();
    st_t act, exp;
    // Mid-stream: put a real instruction in ID/EX, then reset between edges.
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 32'h1111_2222, 32'h0);
    clock_in();
    void'(sb.pop_front());
    #2 reset = 1'b1;
    #1;
    model_reset();
    act = get_act();
    checks++;
    if (act !== st_t'(0)) begin
      errors++;
      $display("FAIL reset_regs actual=%h required=0", act);
    end
    checks++;
    if ({stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt} !== 36'd0) begin
      errors++;
      $display("FAIL reset_cnt actual=%h/%h required=0", stall_cnt, flush_cnt);
    end
    #1 reset = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 5'd4, 5'd5, 5'd6, 32'hCAFE_0001, 32'h0);
    clock_in();
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if (act !== exp || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_rtype actual=%h required=%h", act, exp);
    end
  endtask

  task automatic test_load_use();
    st_t act, exp;
    int  s0;
    s0 = mstall;
    drive(1'b1, 2'b11, 3'b010, 4'b0001, 5'd9, 5'd8, 5'd0, 32'h0000_0100, 32'h0000_0010);
    clock_in();
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lu_lw actual=%h required=%h", act, exp);
    end
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 5'd8, 5'd10, 5'd11, 32'h0000_0200, 32'h0);
    #1;
    checks++;
    if ({stall, pc_write_en, ifid_write_en} !== 3'b100) begin
      errors++;
      $display("FAIL lu_stall actual=%b required=100", {stall, pc_write_en, ifid_write_en});
    end
    clock_in();
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if (act !== exp || valid_out !== 1'b0 || {wb_out, m_out, ex_out} !== 9'd0) begin
      errors++;
      $display("FAIL lu_bubble actual=%h required=%h", act, exp);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_once actual=%b required=0", stall);
    end
    clock_in();
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if (act !== exp || valid_out !== 1'b1 || rs_out !== 5'd8) begin
      errors++;
      $display("FAIL lu_add_enters actual=%h required=%h", act, exp);
    end
    checks++;
    if (stall_cnt !== 16'(s0 + 1)) begin
      errors++;
      $display("FAIL lu_stall_cnt actual=%0d required=%0d", stall_cnt, s0 + 1);
    end
  endtask

  task automatic test_zero_reg();
    st_t act, exp;
    drive(1'b1, 2'b11, 3'b010, 4'b0001, 5'd3, 5'd0, 5'd0, 32'h0, 32'h4);
    clock_in();
    void'(sb.pop_front());
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd7, 32'h0000_0033, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_stall actual=%b required=0", stall);
    end
    clock_in();
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if (act !== exp || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL zero_no_bubble actual=%h required=%h", act, exp);
    end
  endtask

  task automatic test_flush_hazard();
    st_t act, exp;
    int  s0, f0;
    drive(1'b1, 2'b11, 3'b010, 4'b0001, 5'd2, 5'd12, 5'd0, 32'h0, 32'h8);
    clock_in();
    void'(sb.pop_front());
    s0 = mstall;
    f0 = mflush;
    drive(1'b1, 2'b10, 3'b000, 4'b1100, 5'd12, 5'd13, 5'd14, 32'h0000_0044, 32'h0);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || pc_write_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall actual=%b required=0", stall);
    end
    clock_in();
    flush = 1'b0;
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if (act !== exp || {wb_out, m_out, ex_out, valid_out} !== 10'd0) begin
      errors++;
      $display("FAIL flush_zero actual=%h required=%h", act, exp);
    end
    checks++;
    if (flush_cnt !== 16'(f0 + 1) || stall_cnt !== 16'(s0)) begin
      errors++;
      $display("FAIL flush_cnts actual=%0d/%0d required=%0d/%0d",
               flush_cnt, stall_cnt, f0 + 1, s0);
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    drive(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    clock_in();
    void'(sb.pop_front());
    cnt_clr = 1'b0;
    flush   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clock_in();
      void'(sb.pop_front());
      checks++;
      if (s_flush_cnt !== 2'(mflush_s) || flush_cnt !== 16'(mflush)) begin
        errors++;
        $display("FAIL sat_flush_%0d actual=%0d/%0d required=%0d/%0d",
                 i, s_flush_cnt, flush_cnt, mflush_s, mflush);
      end
    end
    checks++;
    if (s_flush_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold actual=%0d required=3", s_flush_cnt);
    end
    cnt_clr = 1'b1;
    clock_in();
    void'(sb.pop_front());
    cnt_clr = 1'b0;
    flush   = 1'b0;
    checks++;
    if ({s_flush_cnt, flush_cnt, stall_cnt} !== 34'd0) begin
      errors++;
      $display("FAIL sat_clr actual=%0d/%0d/%0d required=0", s_flush_cnt, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_beq_passthrough();
    st_t act, exp, mask;
    mask = '1;
    mask.wb[0] = 1'b0;
    mask.ex[3] = 1'b0;
    drive(1'b1, 2'b01, 3'b100, 4'b1010, 5'd4, 5'd5, 5'd0, 32'h0000_0005, 32'hFFFF_FFFC);
    clock_in();
    exp = sb.pop_front();
    act = get_act();
    checks++;
    if ((act & mask) !== (exp & mask) || rdata1_out !== 32'h0000_0005 ||
        imm_out !== 32'hFFFF_FFFC || m_out !== 3'b100) begin
      errors++;
      $display("FAIL beq_pass actual=%h required=%h", act & mask, exp & mask);
    end
  endtask

  task automatic test_back_to_back();
    st_t act, exp;
    logic es;
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000,
            4'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), $urandom, $urandom);
      flush   = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 29) == 0);
      #1;
      es = exp_stall();
      checks++;
      if (stall !== es || pc_write_en !== ~es) begin
        errors++;
        $display("FAIL b2b_stall_%0d actual=%b required=%b", i, stall, es);
      end
      clock_in();
      exp = sb.pop_front();
      act = get_act();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL b2b_regs_%0d actual=%h required=%h", i, act, exp);
      end
    end
    flush   = 1'b0;
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt !== 16'(mstall) || flush_cnt !== 16'(mflush) ||
        s_stall_cnt !== 2'(mstall_s) || s_flush_cnt !== 2'(mflush_s)) begin
      errors++;
      $display("FAIL b2b_cnts actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
               stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
               mstall, mflush, mstall_s, mflush_s);
    end
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    pc4_in  = 32'h0040_0000;
    drive(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    model_reset();
    #12 reset = 1'b0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_flush_hazard();
    test_saturation();
    test_beq_passthrough();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS datapath. Registers the decoder's WB/M/EX control groups alongside the ID-stage operands and register fields for the EX stage.
- Contains load-use hazard detection: freezes PC and IF/ID and inserts a bubble when required.
- Handles squash on a taken branch resolved in MEM.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- DATA_W, 32, width of data operands, PC+4 and immediate.
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  taken branch resolved in MEM; squash the instruction entering ID/EX.
- id_valid  in  1  IF/ID holds a real instruction.
- wb_in  in  2  {RegWrite, MemtoReg} from decoder.
- m_in  in  3  {Branch, MemRead, MemWrite} from decoder.
- ex_in  in  4  {RegDst, ALUOp[1:0], ALUSrc} from decoder.
- pc4_in  in  DATA_W  PC+4 of the ID instruction.
- rdata1_in, rdata2_in  in  DATA_W  register-file read data.
- imm_in  in  DATA_W  sign-extended immediate.
- rs_in, rt_in, rd_in  in  REG_W  instruction fields.
- cnt_clr  in  1  synchronous clear of both counters.
- wb_out, m_out, ex_out  out  2/3/4  registered control.
- pc4_out, rdata1_out, rdata2_out, imm_out  out  DATA_W  registered data.
- rs_out, rt_out, rd_out  out  REG_W  registered fields.
- valid_out  out  1  ID/EX holds a real instruction.
- stall  out  1  combinational; freeze PC and IF/ID.
- pc_write_en, ifid_write_en  out  1  combinational, equal to ~stall.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Behaviour:
- Reset (async, immediate, including mid-operation): every registered output is 0. valid_out=0, counters=0.
- Hazard: `hazard = valid_out & m_out[1] & (rt_out != 0) & id_valid & ((rt_out == rs_in) | (rt_out == rt_in))`. The check is conservative; both source fields are always compared.
- `stall = hazard & ~flush`. A flush takes priority because the IF/ID instruction is being discarded anyway.
- Next-state priority each edge: reset > flush > stall > normal.
  - flush: wb/m/ex_out <= 0, valid_out <= 0. Data and fields capture the inputs (don't-care).
  - stall: bubble. wb/m/ex_out <= 0, valid_out <= 0. Data and fields capture the inputs. Upstream holds, so the stalled instruction is re-presented next cycle.
  - normal: all outputs capture the inputs, valid_out <= id_valid. Control is zeroed when id_valid=0.
- Latency: exactly one cycle from input to output. A stall lasts exactly one cycle per load-use pair, because the bubble clears valid_out and m_out.
- Decoder don't-care bits (X in wb_in[0] / ex_in[3] for sw and beq) are registered as-is. No sanitisation is done; checkers mask them.
- Counters:
  - stall_cnt +1 on each edge with stall=1; flush_cnt +1 on each edge with flush=1.
  - Both saturate at all-ones with no wrap.
  - cnt_clr zeroes both and overrides an increment in the same cycle.
- No combinational path from any input to any registered output. stall depends combinationally on flush, id_valid, rs_in, rt_in.

Decomposition:
- Shared package mips_pkg holds:
  - widths WB_W=2, M_W=3, EX_W=4;
  - bit indices WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, EX_REGDST=3, EX_ALUOP hi/lo=2/1, EX_ALUSRC=0;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
- One combinational sub-module, hazard_detect, computes hazard/stall from the ID/EX and IF/ID fields. The registers and counters remain in id_ex_stage.

Test Plan:
- Reset mid-stream: reset=1 asynchronously between edges -> all outputs 0 immediately; after release, first R-type (wb_in=2'b10, m_in=3'b000, ex_in=4'b1100) appears one edge later with valid_out=1.
- Load-use: lw $t0 (m_in=3'b010, rt_in=8), then add using rs_in=8 -> stall=1 for exactly one cycle; next cycle ID/EX shows wb/m/ex=0, valid_out=0; the add enters on the following edge; stall_cnt=1.
- No hazard with $zero: lw with rt=0 followed by use of rs=0 -> stall=0, no bubble.
- Flush during hazard: lw in ID/EX, dependent instruction in ID, flush=1 -> stall=0, ID/EX zeroed, valid_out=0, flush_cnt=1, stall_cnt unchanged.
- Counter saturation with CNT_W=2: four consecutive flushes -> flush_cnt=3 and holds; cnt_clr together with flush -> 0.
- Pass-through: beq (m_in=3'b100, rdata1_in=32'h0000_0005, imm_in=32'hFFFF_FFFC) -> identical values at outputs one edge later; masked bits are ignored by the checker.
